// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with seed load, multi-shift
// advance and lock-up recovery. The rnd_out, rnd_valid and lockup outputs
// are registered.
// Optional feature: define LFSR_PERIOD_CNT_EN to add the period detector
// and its period_done output.
module lfsr_gen #(
   parameter int               WIDTH    = 16,
   parameter int               MODE     = 0,
   parameter logic [WIDTH-1:0] FIB_TAPS = 16'h002D,
   parameter logic [WIDTH-1:0] GAL_POLY = 16'hB400,
   parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
   parameter int               STEPS    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] rnd_out,
   output logic             rnd_valid,
   output logic             lockup
`ifdef LFSR_PERIOD_CNT_EN
   ,
   output logic             period_done
`endif
);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] adv_state;
   logic [WIDTH-1:0] load_val;

   // One single-bit shift of the selected LFSR structure.
   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      if (MODE == 1) begin
         r = (s >> 1) ^ (s[0] ? GAL_POLY : '0);
      end else begin
         r = {^(s & FIB_TAPS), s[WIDTH-1:1]};
      end
      return r;
   endfunction

   // STEPS shifts unrolled into one combinational advance.
   always_comb begin
      adv_state = state;
      for (int i = 0; i < STEPS; i++) begin
         adv_state = shift1(adv_state);
      end
   end

   // An all-zero seed is replaced so the zero state is never entered.
   always_comb begin
      load_val = (seed_in == '0) ? SEED : seed_in;
   end

   // Core state: zero-state recovery, then load, then step, else hold.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= SEED;
         rnd_valid <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         rnd_valid <= 1'b0;
         if (state == '0) begin
            state     <= SEED;
            lockup    <= 1'b1;
            rnd_valid <= 1'b1;
         end else if (load) begin
            state     <= load_val;
            rnd_valid <= 1'b1;
            if (seed_in == '0) begin
               lockup <= 1'b1;
            end
         end else if (step) begin
            state     <= adv_state;
            rnd_valid <= 1'b1;
         end
      end
   end

   assign rnd_out = state;

`ifdef LFSR_PERIOD_CNT_EN
   logic [WIDTH-1:0] seed_reg;
   logic [WIDTH-1:0] adv_count;

   // Tracks the last seed and counts advances until the state returns to it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seed_reg    <= SEED;
         adv_count   <= '0;
         period_done <= 1'b0;
      end else begin
         period_done <= 1'b0;
         if (state == '0) begin
            seed_reg  <= SEED;
            adv_count <= '0;
         end else if (load) begin
            seed_reg  <= load_val;
            adv_count <= '0;
         end else if (step) begin
            if (adv_state == seed_reg) begin
               period_done <= 1'b1;
               adv_count   <= '0;
            end else begin
               adv_count <= adv_count + 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: randomized self-checking bench for lfsr_gen. Three instances
// share the stimulus: Fibonacci STEPS=1, Galois STEPS=1, Fibonacci STEPS=2.
module tb_lfsr_gen;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        step = 1'b0;
   logic        load = 1'b0;
   logic [15:0] seed_in = 16'h0000;

   logic [15:0] fib_out, gal_out, fib2_out;
   logic        fib_valid, gal_valid, fib2_valid;
   logic        fib_lock, gal_lock, fib2_lock;
`ifdef LFSR_PERIOD_CNT_EN
   logic        fib_pd, gal_pd, fib2_pd;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] m_fib, m_gal, m_fib2;
   logic        m_valid, m_lock;

   always #5 clock = ~clock;

   lfsr_gen #(.WIDTH(16), .MODE(0), .STEPS(1)) u_fib (
      .clock(clock), .reset(reset), .step(step), .load(load), .seed_in(seed_in),
      .rnd_out(fib_out), .rnd_valid(fib_valid), .lockup(fib_lock)
`ifdef LFSR_PERIOD_CNT_EN
      , .period_done(fib_pd)
`endif
   );

   lfsr_gen #(.WIDTH(16), .MODE(1), .STEPS(1)) u_gal (
      .clock(clock), .reset(reset), .step(step), .load(load), .seed_in(seed_in),
      .rnd_out(gal_out), .rnd_valid(gal_valid), .lockup(gal_lock)
`ifdef LFSR_PERIOD_CNT_EN
      , .period_done(gal_pd)
`endif
   );

   lfsr_gen #(.WIDTH(16), .MODE(0), .STEPS(2)) u_fib2 (
      .clock(clock), .reset(reset), .step(step), .load(load), .seed_in(seed_in),
      .rnd_out(fib2_out), .rnd_valid(fib2_valid), .lockup(fib2_lock)
`ifdef LFSR_PERIOD_CNT_EN
      , .period_done(fib2_pd)
`endif
   );

   // Polynomial x^16+x^14+x^13+x^11, right-shifting Fibonacci form:
   // new MSB is the parity of the tapped bits.
   function automatic logic [15:0] fib_ref(input logic [15:0] s);
      int fb;
      fb = $countones(s & 16'h002D) % 2;
      return 16'(int'(s) / 2 + fb * 32768);
   endfunction

   // Galois form: halve, and if an odd value was halved apply the toggle mask.
   function automatic logic [15:0] gal_ref(input logic [15:0] s);
      logic [15:0] h;
      h = 16'(int'(s) / 2);
      return (int'(s) % 2 == 1) ? (h ^ 16'hB400) : h;
   endfunction

   task automatic model_reset();
      m_fib = 16'hACE1; m_gal = 16'hACE1; m_fib2 = 16'hACE1;
      m_valid = 1'b0; m_lock = 1'b0;
   endtask

   // Drive one cycle of inputs, update the model, sample 1 time unit after the edge.
   task automatic tick(input logic st, input logic ld, input logic [15:0] sd);
      step = st; load = ld; seed_in = sd;
      if (ld) begin
         if (sd == 16'h0000) begin
            m_fib = 16'hACE1; m_gal = 16'hACE1; m_fib2 = 16'hACE1; m_lock = 1'b1;
         end else begin
            m_fib = sd; m_gal = sd; m_fib2 = sd;
         end
         m_valid = 1'b1;
      end else if (st) begin
         m_fib  = fib_ref(m_fib);
         m_gal  = gal_ref(m_gal);
         m_fib2 = fib_ref(fib_ref(m_fib2));
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; step = 1'b0; load = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (fib_out !== 16'hACE1 || gal_out !== 16'hACE1 || fib2_out !== 16'hACE1) begin
         failures++;
         $display("FAIL reset_state got fib=%h gal=%h fib2=%h exp=ace1", fib_out, gal_out, fib2_out);
      end
      checks++;
      if ({fib_valid, fib_lock, gal_valid, gal_lock} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got valid=%b lock=%b exp valid=0 lock=0", fib_valid, fib_lock);
      end
      reset = 1'b1;
      tick(1'b0, 1'b0, 16'h0000);
      checks++;
      if (fib_out !== 16'hACE1 || fib_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle got out=%h valid=%b exp out=ace1 valid=0", fib_out, fib_valid);
      end
   endtask

   task automatic test_single_step();
      tick(1'b1, 1'b0, 16'h0000);
      checks++;
      if (fib_out !== 16'h5670 || fib_valid !== 1'b1) begin
         failures++;
         $display("FAIL fib_first_step got out=%h valid=%b exp out=5670 valid=1", fib_out, fib_valid);
      end
      checks++;
      if (gal_out !== 16'hE270 || gal_valid !== 1'b1) begin
         failures++;
         $display("FAIL gal_first_step got out=%h valid=%b exp out=e270 valid=1", gal_out, gal_valid);
      end
      checks++;
      if (fib2_out !== m_fib2 || fib2_valid !== 1'b1) begin
         failures++;
         $display("FAIL fib2_first_step got out=%h valid=%b exp out=%h valid=1", fib2_out, fib2_valid, m_fib2);
      end
      tick(1'b0, 1'b0, 16'h0000);
      checks++;
      if (fib_out !== 16'h5670 || fib_valid !== 1'b0 || gal_out !== 16'hE270) begin
         failures++;
         $display("FAIL hold_after_step got fib=%h valid=%b gal=%h exp fib=5670 valid=0 gal=e270",
                  fib_out, fib_valid, gal_out);
      end
   endtask

   task automatic test_zero_load();
      tick(1'b1, 1'b1, 16'h0000);
      checks++;
      if (fib_out !== 16'hACE1 || gal_out !== 16'hACE1 || fib2_out !== 16'hACE1) begin
         failures++;
         $display("FAIL zero_load_state got fib=%h gal=%h fib2=%h exp=ace1", fib_out, gal_out, fib2_out);
      end
      checks++;
      if (fib_lock !== 1'b1 || gal_lock !== 1'b1 || fib_valid !== 1'b1) begin
         failures++;
         $display("FAIL zero_load_flags got lock=%b valid=%b exp lock=1 valid=1", fib_lock, fib_valid);
      end
   endtask

   task automatic test_load_step();
      tick(1'b1, 1'b1, 16'h1234);
      checks++;
      if (fib_out !== 16'h1234 || gal_out !== 16'h1234 || fib2_out !== 16'h1234) begin
         failures++;
         $display("FAIL load_priority got fib=%h gal=%h fib2=%h exp=1234", fib_out, gal_out, fib2_out);
      end
      checks++;
      if (fib_lock !== 1'b1) begin
         failures++;
         $display("FAIL lockup_sticky got %b exp 1", fib_lock);
      end
      tick(1'b1, 1'b0, 16'h0000);
      checks++;
      if (fib_out !== m_fib || gal_out !== m_gal || fib2_out !== m_fib2) begin
         failures++;
         $display("FAIL step_after_load got fib=%h gal=%h fib2=%h exp fib=%h gal=%h fib2=%h",
                  fib_out, gal_out, fib2_out, m_fib, m_gal, m_fib2);
      end
      // Asynchronous reset mid-stream with step still requested
      reset = 1'b0;
      #1;
      checks++;
      if (fib_out !== 16'hACE1 || gal_out !== 16'hACE1 || fib_lock !== 1'b0 || fib_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got fib=%h gal=%h lock=%b valid=%b exp ace1 ace1 0 0",
                  fib_out, gal_out, fib_lock, fib_valid);
      end
      load = 1'b1; seed_in = 16'h4321;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (fib_out !== 16'hACE1 || fib_valid !== 1'b0) begin
         failures++;
         $display("FAIL inputs_ignored_in_reset got out=%h valid=%b exp out=ace1 valid=0", fib_out, fib_valid);
      end
      load = 1'b0; step = 1'b0;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      int bad;
      logic st, ld;
      logic [15:0] sd;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         st = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 9) == 0);
         sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         tick(st, ld, sd);
         checks++;
         if (fib_out !== m_fib || gal_out !== m_gal || fib2_out !== m_fib2 ||
             fib_valid !== m_valid || gal_valid !== m_valid || fib2_valid !== m_valid ||
             fib_lock !== m_lock || fib2_lock !== m_lock) begin
            failures++;
            bad++;
            if (bad <= 5)
               $display("FAIL random_cycle_%0d got fib=%h gal=%h fib2=%h v=%b l=%b exp fib=%h gal=%h fib2=%h v=%b l=%b",
                        i, fib_out, gal_out, fib2_out, fib_valid, fib_lock,
                        m_fib, m_gal, m_fib2, m_valid, m_lock);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      bad = 0;
      tick(1'b0, 1'b1, 16'hBEEF);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 16'h0000);
         checks++;
         if (fib_valid !== 1'b1 || fib_out !== m_fib || gal_out !== m_gal || fib2_out !== m_fib2) begin
            failures++;
            bad++;
            if (bad <= 3)
               $display("FAIL back_to_back_%0d got fib=%h gal=%h fib2=%h valid=%b exp %h %h %h 1",
                        i, fib_out, gal_out, fib2_out, fib_valid, m_fib, m_gal, m_fib2);
         end
      end
      tick(1'b0, 1'b0, 16'h0000);
      checks++;
      if (fib_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_drops_idle got %b exp 0", fib_valid);
      end
   endtask

`ifdef LFSR_PERIOD_CNT_EN
   task automatic test_period();
      int  adv;
      bit  zero_seen;
      bit  done;
      adv = 0; zero_seen = 0; done = 0;
      reset = 1'b0; step = 1'b0; load = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      model_reset();
      step = 1'b1;
      while (!done && adv < 70000) begin
         @(posedge clock); #1;
         adv++;
         if (fib_out == 16'h0000) zero_seen = 1;
         if (fib_pd === 1'b1) done = 1;
      end
      step = 1'b0;
      checks++;
      if (adv != 65535) begin
         failures++;
         $display("FAIL period_length got %0d exp 65535", adv);
      end
      checks++;
      if (fib_out !== 16'hACE1 || zero_seen) begin
         failures++;
         $display("FAIL period_state got out=%h zero_seen=%0d exp out=ace1 zero_seen=0", fib_out, zero_seen);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_step();
      test_zero_load();
      test_load_step();
      test_random();
      test_back_to_back();
`ifdef LFSR_PERIOD_CNT_EN
      test_period();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
